dma_arbiter: RTL
================

Name: dma_arbiter

Overview:
- Multi-channel DMA arbiter that sits between the per-channel controllers and the single shared DMA engine.
- Collects channel requests and picks one winner: highest priority first, round-robin among equal priorities.
- Issues the one-cycle grant the channel uses to latch its engine parameters, then starts the engine and drives the engine mux select.
- Routes engine done/error back to the granted channel and applies a completion watchdog.

Parameters:
- NUM_CH, 4, number of DMA channels (2..8).
- PRIO_W, 2, priority field width per channel.
- TIMEOUT_CYCLES, 65535, engine completion watchdog in cycles. 0 disables the watchdog.
- Localparam SEL_W = $clog2(NUM_CH).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ch_request  in  NUM_CH  per-channel request; level, held while the channel waits for grant.
- ch_priority  in  NUM_CH*PRIO_W  packed priorities; channel i uses bits [i*PRIO_W +: PRIO_W]; larger value means higher priority.
- ch_grant  out  NUM_CH  one-hot grant, asserted for exactly one cycle.
- ch_done  out  NUM_CH  one-cycle completion pulse to the granted channel.
- ch_error  out  NUM_CH  error to the granted channel, held for two cycles (completion cycle plus RELEASE).
- engine_sel  out  SEL_W  index of the granted channel, drives the engine parameter mux.
- engine_start  out  1  one-cycle pulse; engine parameters are valid while it is high.
- engine_abort  out  1  one-cycle pulse when the watchdog fires.
- engine_done  in  1  engine completion pulse.
- engine_error  in  1  engine error pulse.
- arb_busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered. Reset values: ch_grant=0, ch_done=0, ch_error=0, engine_sel=0, engine_start=0, engine_abort=0, arb_busy=0.
- Reset also sets state=IDLE, last_grant=NUM_CH-1 (so channel 0 wins the first tie) and the watchdog count to 0.
- Reset mid-transfer returns to IDLE immediately. No done/error is reported.
- FSM states and transitions:
  - IDLE: if any ch_request is set, compute the winner, register win_idx, go to GRANT.
  - GRANT: ch_grant[win_idx]=1 and engine_sel=win_idx. Go to START.
  - START: engine_start=1. Clear the watchdog. Go to WAIT.
  - WAIT: increment the watchdog each cycle. On engine_done or engine_error, go to RELEASE. On watchdog reaching TIMEOUT_CYCLES-1 with no response, go to RELEASE with a forced error.
  - RELEASE: hold ch_error if it was set. Update last_grant=win_idx. Go to IDLE.
- Output timing:
  - ch_done[win_idx] and ch_error[win_idx] assert the cycle after the completing cycle in WAIT, so they are visible while the FSM is in RELEASE.
  - ch_error persists for exactly 2 cycles: the completion cycle and the RELEASE cycle, so the channel's COMPLETE state samples it.
  - engine_sel is held from GRANT through RELEASE. It keeps its last value while in IDLE.
- Winner selection (combinational in IDLE):
  - maxp = highest priority among requesting channels.
  - Among requesters with priority == maxp, the first index scanning circularly from last_grant+1 (mod NUM_CH) wins.
  - Requests from non-requesting channels are ignored.
- Latency: request seen in IDLE at cycle 0 → grant in cycle 1 → engine_start in cycle 2. Minimum re-arbitration gap is 1 IDLE cycle after RELEASE.
- Simultaneous engine_done and engine_error: ch_done and ch_error both assert (error wins the status).
- Watchdog timeout: ch_done, ch_error and engine_abort all pulse together, with ch_error held for 2 cycles.
- Engine done/error pulses received outside WAIT are ignored.
- ch_request changes after grant are ignored until the FSM returns to IDLE.

Decomposition:
- Shared package/header dma_defines.vh gains:
  - arbiter state encodings ARB_IDLE..ARB_RELEASE (3 bits);
  - default DMA_NUM_CH and DMA_TIMEOUT_CYCLES.
- One natural sub-module: dma_rr_prio_select (combinational winner picker).
  - Inputs: request, packed priority, last_grant.
  - Outputs: valid, win_idx.
  - Instantiated once; reusable by a future bus arbiter.

Test Plan:
- Single request: ch_request=4'b0100 at cycle 0 → ch_grant=4'b0100 at cycle 1, engine_sel=2 and engine_start at cycle 2; engine_done at cycle 5 → ch_done=4'b0100 one cycle; arb_busy drops after RELEASE.
- Priority: ch_request=4'b1011 with priorities {ch3=1, ch1=3, ch0=3}, last_grant=3 → grant ch0; after it completes with ch0/ch1 still requesting → grant ch1 (round-robin), then ch0, never ch3 while ch0/ch1 request.
- Equal-priority rotation: all 4 channels requesting at priority 0 continuously → grant order 0,1,2,3,0.
- Error path: engine_error in WAIT → ch_error[idx] high exactly 2 cycles, ch_done pulses once; done+error in the same cycle → same response.
- Watchdog: TIMEOUT_CYCLES=8 with no engine response → engine_abort pulse 8 cycles after engine_start, ch_error 2 cycles, FSM back to IDLE; TIMEOUT_CYCLES=0 with no response → stays in WAIT.
- Reset mid-WAIT: assert rst for 1 cycle → all outputs 0 next cycle, no ch_done; with ch_request=4'b0001 afterwards → grant ch0.

Source files
------------

// File: rtl/dma_arbiter_pkg.sv
// dma_arbiter_pkg
//   Shared definitions for the DMA arbitration slice: arbiter FSM state
//   encodings and default sizing for channel count, priority width and the
//   engine completion watchdog.
package dma_arbiter_pkg;

   localparam int DMA_NUM_CH         = 4;
   localparam int DMA_PRIO_W         = 2;
   localparam int DMA_TIMEOUT_CYCLES = 65535;

   typedef enum logic [2:0] {
      ARB_IDLE    = 3'd0,
      ARB_GRANT   = 3'd1,
      ARB_START   = 3'd2,
      ARB_WAIT    = 3'd3,
      ARB_RELEASE = 3'd4
   } arb_state_e;

endpackage : dma_arbiter_pkg

// File: rtl/dma_rr_prio_select.sv
// dma_rr_prio_select
//   Combinational winner picker: highest priority among the requesters wins.
//   Ties are broken round-robin, scanning circularly from last_grant+1.
// Ports:
//   request    in   NUM_CH         request vector
//   prio       in   NUM_CH*PRIO_W  packed priorities, channel i at [i*PRIO_W +: PRIO_W]
//   last_grant in   SEL_W          index granted most recently
//   valid      out  1              at least one request present
//   win_idx    out  SEL_W          winning channel index (0 when !valid)
module dma_rr_prio_select #(
   parameter  int NUM_CH = 4,
   parameter  int PRIO_W = 2,
   localparam int SEL_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0]        request,
   input  logic [NUM_CH*PRIO_W-1:0] prio,
   input  logic [SEL_W-1:0]         last_grant,
   output logic                     valid,
   output logic [SEL_W-1:0]         win_idx
);

   logic [PRIO_W-1:0] prio_a [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
      assign prio_a[g] = prio[g*PRIO_W +: PRIO_W];
   end

   always_comb begin
      logic [PRIO_W-1:0] maxp;
      logic [SEL_W-1:0]  idx;
      logic              found;
      // NOTE: every variable gets a value before any branch reads or skips
      // it; a path that leaves one unassigned would infer a latch.
      maxp    = '0;
      idx     = '0;
      found   = 1'b0;
      win_idx = '0;
      valid   = |request;

      for (int i = 0; i < NUM_CH; i++) begin
         if (request[i] && (prio_a[i] > maxp)) maxp = prio_a[i];
      end

      // k runs 1..NUM_CH so last_grant itself is considered last.
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = SEL_W'((int'(last_grant) + k) % NUM_CH);
         if (!found && request[idx] && (prio_a[idx] == maxp)) begin
            found   = 1'b1;
            win_idx = idx;
         end
      end
   end

endmodule : dma_rr_prio_select

// File: rtl/dma_arbiter.sv
// dma_arbiter
//   Arbitrates the single shared DMA engine among NUM_CH channel controllers.
//   Picks a winner in IDLE, pulses its grant, starts the engine, waits for
//   done/error (or the watchdog), then reports completion to the winner.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   ch_request    in   per-channel request level
//   ch_priority   in   packed per-channel priorities (larger is higher)
//   ch_grant      out  one-hot grant pulse
//   ch_done       out  one-cycle completion pulse to the granted channel
//   ch_error      out  error to the granted channel, held two cycles
//   engine_sel    out  granted channel index for the engine parameter mux
//   engine_start  out  engine start pulse
//   engine_abort  out  watchdog abort pulse
//   engine_done   in   engine completion pulse
//   engine_error  in   engine error pulse
//   arb_busy      out  high whenever the FSM is outside IDLE
module dma_arbiter
   import dma_arbiter_pkg::*;
#(
   parameter  int NUM_CH         = DMA_NUM_CH,
   parameter  int PRIO_W         = DMA_PRIO_W,
   parameter  int TIMEOUT_CYCLES = DMA_TIMEOUT_CYCLES,
   localparam int SEL_W          = $clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ch_request,
   input  logic [NUM_CH*PRIO_W-1:0] ch_priority,
   output logic [NUM_CH-1:0]        ch_grant,
   output logic [NUM_CH-1:0]        ch_done,
   output logic [NUM_CH-1:0]        ch_error,
   output logic [SEL_W-1:0]         engine_sel,
   output logic                     engine_start,
   output logic                     engine_abort,
   input  logic                     engine_done,
   input  logic                     engine_error,
   output logic                     arb_busy
);

   localparam int               WD_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   arb_state_e        state_q;
   logic [SEL_W-1:0]  win_idx_q;
   logic [SEL_W-1:0]  last_grant_q;
   logic [WD_W-1:0]   wd_q;
   logic [WD_W-1:0]   wd_d;
   logic              wd_fire;
   logic [NUM_CH-1:0] ch_grant_q;
   logic [NUM_CH-1:0] ch_done_q;
   logic [NUM_CH-1:0] ch_error_q;
   logic [SEL_W-1:0]  engine_sel_q;
   logic              engine_start_q;
   logic              engine_abort_q;
   logic              arb_busy_q;
   logic              sel_valid;
   logic [SEL_W-1:0]  sel_idx;
   logic [NUM_CH-1:0] win_onehot;

   dma_rr_prio_select #(
      .NUM_CH (NUM_CH),
      .PRIO_W (PRIO_W)
   ) u_select (
      .request    (ch_request),
      .prio       (ch_priority),
      .last_grant (last_grant_q),
      .valid      (sel_valid),
      .win_idx    (sel_idx)
   );

   assign win_onehot = NUM_CH'(1) << win_idx_q;

   // The watchdog compares the value it is about to hold, so the abort lands
   // TIMEOUT_CYCLES cycles after the start pulse, counting START itself.
   assign wd_d    = wd_q + 1'b1;
   assign wd_fire = (TIMEOUT_CYCLES != 0) && ((TIMEOUT_CYCLES == 1) || (wd_d == WD_LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ARB_IDLE;
         win_idx_q      <= '0;
         last_grant_q   <= SEL_W'(NUM_CH - 1);
         wd_q           <= '0;
         ch_grant_q     <= '0;
         ch_done_q      <= '0;
         ch_error_q     <= '0;
         engine_sel_q   <= '0;
         engine_start_q <= 1'b0;
         engine_abort_q <= 1'b0;
         arb_busy_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; these pulse defaults
         // are overridden later in the same block by the state that fires them.
         ch_grant_q     <= '0;
         ch_done_q      <= '0;
         engine_start_q <= 1'b0;
         engine_abort_q <= 1'b0;

         case (state_q)
            ARB_IDLE: begin
               // An error from RELEASE stays visible for this one extra cycle.
               ch_error_q <= '0;
               if (sel_valid) begin
                  win_idx_q    <= sel_idx;
                  ch_grant_q   <= NUM_CH'(1) << sel_idx;
                  engine_sel_q <= sel_idx;
                  arb_busy_q   <= 1'b1;
                  state_q      <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               engine_start_q <= 1'b1;
               state_q        <= ARB_START;
            end
            ARB_START: begin
               wd_q    <= '0;
               state_q <= ARB_WAIT;
            end
            ARB_WAIT: begin
               wd_q <= wd_d;
               if (engine_done || engine_error) begin
                  ch_done_q <= win_onehot;
                  if (engine_error) ch_error_q <= win_onehot;
                  state_q <= ARB_RELEASE;
               end else if (wd_fire) begin
                  ch_done_q      <= win_onehot;
                  ch_error_q     <= win_onehot;
                  engine_abort_q <= 1'b1;
                  state_q        <= ARB_RELEASE;
               end
            end
            ARB_RELEASE: begin
               last_grant_q <= win_idx_q;
               arb_busy_q   <= 1'b0;
               state_q      <= ARB_IDLE;
            end
            default: begin
               arb_busy_q <= 1'b0;
               state_q    <= ARB_IDLE;
            end
         endcase
      end
   end

   assign ch_grant     = ch_grant_q;
   assign ch_done      = ch_done_q;
   assign ch_error     = ch_error_q;
   assign engine_sel   = engine_sel_q;
   assign engine_start = engine_start_q;
   assign engine_abort = engine_abort_q;
   assign arb_busy     = arb_busy_q;

endmodule : dma_arbiter
